alu_cmd_issuer: RTL

Command-driven initiator for the `ALU` block: it accepts operation commands over a valid/ready handshake, reads operands from a small internal register file, and drives the ALU's `A`/`B`/`op` ports. It captures `Y` and `ONZ`, writes the result back, and returns the result and flags over a response handshake. It sits between a host or sequencer and a combinational `ALU` instance, and owns all sequencing around it.

---
 rtl/alu_cmd_issuer_if.sv | 33 +++
 rtl/alu_cmd_issuer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer_if.sv
// Command, response and ALU-side signal bundle for alu_cmd_issuer.
// slave  : the issuer itself.
// master : the host/sequencer plus the ALU it is paired with.
interface alu_cmd_issuer_if #(
  parameter int width = 8,
  parameter int aw    = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [aw-1:0]    cmd_rs1;
  logic [aw-1:0]    cmd_rs2;
  logic [aw-1:0]    cmd_rd;
  logic [width-1:0] alu_a;
  logic [width-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [width-1:0] alu_y;
  logic [2:0]       alu_onz;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [width-1:0] rsp_y;
  logic [2:0]       rsp_onz;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, alu_y, alu_onz, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_y, rsp_onz
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, alu_y, alu_onz, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_y, rsp_onz
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: accepts ALU commands, reads operands from a small register
// file, drives a combinational ALU for one cycle, writes the result back and
// returns result/flags over a response handshake.
// Optional build macro ALU_CMD_ISSUER_FLAG_CHECK_EN: enables the sticky
// flag-consistency checker on err (otherwise err is tied low).
module alu_cmd_issuer #(
  parameter  int width = 8,
  parameter  int regs  = 4,
  localparam int aw    = $clog2(regs)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_en,
  input  logic [aw-1:0]    ld_addr,
  input  logic [width-1:0] ld_data,
  alu_cmd_issuer_if.slave  bus,
  output logic [2:0]       flags,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state_q, state_d;
  logic [width-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic [2:0]       op_q, op_d, onz_q, onz_d;
  logic [aw-1:0]    rd_q, rd_d;
  logic [width-1:0] rf_q [regs];
  logic [width-1:0] rf_d [regs];

  // Next state, operand latch, capture and register-file writes.
  // The load is applied before the writeback so a same-address writeback wins;
  // operands are read from rf_q, so a load on the accept edge is not seen.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rd_d    = rd_q;
    y_d     = y_q;
    onz_d   = onz_q;
    rf_d    = rf_q;
    if (ld_en) rf_d[ld_addr] = ld_data;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        a_d     = rf_q[bus.cmd_rs1];
        b_d     = rf_q[bus.cmd_rs2];
        op_d    = bus.cmd_op;
        rd_d    = bus.cmd_rd;
        state_d = ISSUE;
      end
      ISSUE: begin
        y_d        = bus.alu_y;
        onz_d      = bus.alu_onz;
        rf_d[rd_q] = bus.alu_y;
        state_d    = RESP;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      y_q     <= '0;
      onz_q   <= '0;
      for (int i = 0; i < regs; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      y_q     <= y_d;
      onz_q   <= onz_d;
      rf_q    <= rf_d;
    end
  end

  // rsp_onz and flags are the same captured value: the response copy is
  // only meaningful while rsp_valid, flags is read at any time.
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.rsp_y     = y_q;
  assign bus.rsp_onz   = onz_q;
  assign flags         = onz_q;

`ifdef ALU_CMD_ISSUER_FLAG_CHECK_EN
  logic err_q, err_d, chk_fail;
  logic sa, sb, sy;

  // Flag consistency of the ALU output against its own result and operands.
  always_comb begin
    sa       = a_q[width-1];
    sb       = b_q[width-1];
    sy       = bus.alu_y[width-1];
    chk_fail = (bus.alu_onz[1] != sy) || (bus.alu_onz[0] != (bus.alu_y == '0));
    if (op_q == 3'd0 && sa == sb && sy != sa && !bus.alu_onz[2]) chk_fail = 1'b1;
    if (op_q == 3'd1 && sa != sb && sy != sa && !bus.alu_onz[2]) chk_fail = 1'b1;
    err_d = err_q | ((state_q == ISSUE) && chk_fail);
  end

  // Sticky error until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
